// File: rtl/status_scoreboard_if.sv
// Status-scoreboard bus: golden-table load port, run control, core status
// stream and the result/report outputs, grouped so a driver and the
// scoreboard can be wired with one connection.
interface status_scoreboard_if #(
   parameter int STATUS_W = 3,
   parameter int ADDR_W   = 6,
   parameter int CYC_W    = 17
);
   // golden table load
   logic                i_gld_we;
   logic [ADDR_W-1:0]   i_gld_addr;
   logic [STATUS_W-1:0] i_gld_data;
   // run control
   logic [ADDR_W:0]     i_pat_len;
   logic                i_start;
   // core status stream
   logic [STATUS_W-1:0] i_status;
   logic                i_status_valid;
   // results
   logic                o_busy;
   logic                o_done;
   logic                o_pass;
   logic                o_timeout;
   logic [ADDR_W:0]     o_correct_cnt;
   logic [ADDR_W:0]     o_error_cnt;
   logic                o_err_vld;
   logic [ADDR_W:0]     o_err_idx;
   logic [STATUS_W-1:0] o_err_got;
   logic [CYC_W-1:0]    o_cycle_cnt;

   // driver side (core wrapper / testbench)
   modport master (
      output i_gld_we, i_gld_addr, i_gld_data, i_pat_len, i_start,
             i_status, i_status_valid,
      input  o_busy, o_done, o_pass, o_timeout, o_correct_cnt, o_error_cnt,
             o_err_vld, o_err_idx, o_err_got, o_cycle_cnt
   );

   // scoreboard side
   modport slave (
      input  i_gld_we, i_gld_addr, i_gld_data, i_pat_len, i_start,
             i_status, i_status_valid,
      output o_busy, o_done, o_pass, o_timeout, o_correct_cnt, o_error_cnt,
             o_err_vld, o_err_idx, o_err_got, o_cycle_cnt
   );
endinterface

// File: rtl/status_scoreboard.sv
// Self-checking scoreboard for the core status stream. A loadable golden
// table is compared entry by entry against every valid status during a run.
// Passes and errors are counted, the first mismatch is captured, and the run
// ends on a terminating status code or on a cycle-budget timeout.
module status_scoreboard #(
   parameter int                    STATUS_W  = 3,
   parameter int                    DEPTH     = 64,
   parameter int                    ADDR_W    = 6,
   parameter int                    MAX_CYCLE = 120000,
   parameter int                    CYC_W     = 17,
   parameter logic [STATUS_W-1:0]   END_A     = 3'b100,
   parameter logic [STATUS_W-1:0]   END_B     = 3'b101
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   status_scoreboard_if.slave   sb
);

   localparam int               CNT_W   = ADDR_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CYC_W-1:0] CYC_MAX = {CYC_W{1'b1}};
   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MAX_CYCLE - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Saturating increment shared by the index and both status counters.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == CNT_MAX) begin
         sat_inc = v;
      end else begin
         sat_inc = v + CNT_W'(1);
      end
   endfunction

   state_t              state_q,   state_d;
   logic [CNT_W-1:0]    len_q,     len_d;
   logic [CNT_W-1:0]    idx_q,     idx_d;
   logic [CNT_W-1:0]    corr_q,    corr_d;
   logic [CNT_W-1:0]    err_q,     err_d;
   logic                err_vld_q, err_vld_d;
   logic [CNT_W-1:0]    err_idx_q, err_idx_d;
   logic [STATUS_W-1:0] err_got_q, err_got_d;
   logic [CYC_W-1:0]    cyc_q,     cyc_d;
   logic                pass_q,    pass_d;
   logic                tmo_q,     tmo_d;

   // Golden table: no reset, so a loaded pattern survives reset and re-runs.
   logic [STATUS_W-1:0] gld_q [DEPTH];

   logic [STATUS_W-1:0] gld_rd_s;
   logic                hit_s;
   logic                term_s;
   logic                cyc_last_s;

   // Asynchronous golden read at the current index; index is only used for
   // the table when it is below the latched length, which never exceeds DEPTH.
   assign gld_rd_s   = gld_q[idx_q[ADDR_W-1:0]];
   assign hit_s      = (idx_q < len_q) && (sb.i_status == gld_rd_s);
   assign term_s     = sb.i_status_valid &&
                       ((sb.i_status == END_A) || (sb.i_status == END_B));
   assign cyc_last_s = (cyc_q == CYC_LAST);

   // Next-state and result bookkeeping for the IDLE/RUN/DONE controller.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      idx_d     = idx_q;
      corr_d    = corr_q;
      err_d     = err_q;
      err_vld_d = err_vld_q;
      err_idx_d = err_idx_q;
      err_got_d = err_got_q;
      cyc_d     = cyc_q;
      pass_d    = pass_q;
      tmo_d     = tmo_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (sb.i_start) begin
               // a new run starts clean; the golden table is left as-is
               state_d   = ST_RUN;
               len_d     = sb.i_pat_len;
               idx_d     = '0;
               corr_d    = '0;
               err_d     = '0;
               err_vld_d = 1'b0;
               err_idx_d = '0;
               err_got_d = '0;
               cyc_d     = '0;
               pass_d    = 1'b0;
               tmo_d     = 1'b0;
            end else begin
               state_d = state_q;
            end
         end

         ST_RUN: begin
            if (sb.i_status_valid) begin
               if (hit_s) begin
                  corr_d = sat_inc(corr_q);
               end else begin
                  // mismatch, or a surplus status beyond the pattern length
                  err_d = sat_inc(err_q);
                  if (!err_vld_q) begin
                     err_vld_d = 1'b1;
                     err_idx_d = idx_q;
                     err_got_d = sb.i_status;
                  end else begin
                     err_vld_d = err_vld_q;
                  end
               end
               idx_d = sat_inc(idx_q);
            end else begin
               idx_d = idx_q;
            end

            // a terminating status beats a coincident timeout
            if (term_s) begin
               state_d = ST_DONE;
               tmo_d   = 1'b0;
               pass_d  = (err_d == '0) && (corr_d == len_q);
            end else if (cyc_last_s) begin
               state_d = ST_DONE;
               tmo_d   = 1'b1;
               pass_d  = 1'b0;
            end else begin
               state_d = ST_RUN;
               if (cyc_q != CYC_MAX) begin
                  cyc_d = cyc_q + CYC_W'(1);
               end else begin
                  cyc_d = cyc_q;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Controller and result registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         len_q     <= '0;
         idx_q     <= '0;
         corr_q    <= '0;
         err_q     <= '0;
         err_vld_q <= 1'b0;
         err_idx_q <= '0;
         err_got_q <= '0;
         cyc_q     <= '0;
         pass_q    <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         corr_q    <= corr_d;
         err_q     <= err_d;
         err_vld_q <= err_vld_d;
         err_idx_q <= err_idx_d;
         err_got_q <= err_got_d;
         cyc_q     <= cyc_d;
         pass_q    <= pass_d;
         tmo_q     <= tmo_d;
      end
   end

   // Golden table load, accepted only while no run is in progress.
   always_ff @(posedge i_clk) begin
      if (sb.i_gld_we && (state_q != ST_RUN)) begin
         gld_q[sb.i_gld_addr] <= sb.i_gld_data;
      end else begin
         gld_q[sb.i_gld_addr] <= gld_q[sb.i_gld_addr];
      end
   end

   assign sb.o_busy        = (state_q == ST_RUN);
   assign sb.o_done        = (state_q == ST_DONE);
   assign sb.o_pass        = pass_q;
   assign sb.o_timeout     = tmo_q;
   assign sb.o_correct_cnt = corr_q;
   assign sb.o_error_cnt   = err_q;
   assign sb.o_err_vld     = err_vld_q;
   assign sb.o_err_idx     = err_idx_q;
   assign sb.o_err_got     = err_got_q;
   assign sb.o_cycle_cnt   = cyc_q;

endmodule

// File: tb/tb_status_scoreboard.sv
// Testbench for status_scoreboard: directed scenarios plus randomized runs,
// each checked against a pattern-level reference model of the scoreboard.
module tb_status_scoreboard;

   localparam int STATUS_W  = 3;
   localparam int DEPTH     = 64;
   localparam int ADDR_W    = 6;
   localparam int MAX_CYCLE = 20;
   localparam int CYC_W     = 5;

   logic clk = 1'b0;
   logic rst_n;

   int total = 0;
   int bad   = 0;

   logic [2:0] gold [DEPTH];
   logic [3:0] stim [$];   // {valid, status} per RUN cycle

   always #5 clk = ~clk;

   status_scoreboard_if #(.STATUS_W(STATUS_W), .ADDR_W(ADDR_W), .CYC_W(CYC_W)) sb_if ();

   status_scoreboard #(
      .STATUS_W(STATUS_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
      .MAX_CYCLE(MAX_CYCLE), .CYC_W(CYC_W),
      .END_A(3'b100), .END_B(3'b101)
   ) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .sb     (sb_if)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic load(input int a, input logic [2:0] v);
      sb_if.i_gld_we   = 1'b1;
      sb_if.i_gld_addr = a[ADDR_W-1:0];
      sb_if.i_gld_data = v;
      step();
      sb_if.i_gld_we   = 1'b0;
      gold[a] = v;
   endtask

   function automatic logic is_end(input logic [2:0] s);
      return (s == 3'b100) || (s == 3'b101);
   endfunction

   function automatic logic [2:0] rand_non_end();
      logic [2:0] v;
      do v = 3'($urandom_range(0, 7)); while (is_end(v));
      return v;
   endfunction

   // One run: the k-th valid status is judged against gold[k]; the run ends at
   // the first end code or after MAX_CYCLE run cycles. A golden write is
   // attempted at cycle wr_cyc (if >= 0) and must have no effect.
   task automatic run(input int len, input int wr_cyc);
      int n_ok, n_bad, first_idx, exit_k, nvalid;
      logic first_seen, tmo, pass;
      logic [2:0] first_got, s;
      logic v;

      n_ok = 0; n_bad = 0; first_seen = 1'b0; first_idx = 0; first_got = 3'b000;
      tmo = 1'b0; exit_k = MAX_CYCLE - 1; nvalid = 0;
      for (int k = 0; k < MAX_CYCLE; k++) begin
         {v, s} = (k < stim.size()) ? stim[k] : 4'b0000;
         if (v) begin
            if (nvalid < len && s == gold[nvalid]) n_ok++;
            else begin
               n_bad++;
               if (!first_seen) begin
                  first_seen = 1'b1; first_idx = nvalid; first_got = s;
               end
            end
            nvalid++;
         end
         if (v && is_end(s)) begin
            exit_k = k;
            break;
         end
         if (k == MAX_CYCLE - 1) tmo = 1'b1;
      end
      pass = (n_bad == 0) && (n_ok == len) && !tmo;

      // start edge: a valid status here must be ignored
      sb_if.i_pat_len      = 7'(len);
      sb_if.i_start        = 1'b1;
      sb_if.i_status_valid = 1'b1;
      sb_if.i_status       = 3'($urandom);
      step();
      sb_if.i_start        = 1'b0;
      sb_if.i_gld_we       = 1'b0;
      sb_if.i_status_valid = 1'b0;
      chk("start_busy", 32'(sb_if.o_busy), 32'd1);
      chk("start_corr_clr", 32'(sb_if.o_correct_cnt), 32'd0);
      chk("start_errvld_clr", 32'(sb_if.o_err_vld), 32'd0);

      for (int k = 0; k <= exit_k; k++) begin
         {sb_if.i_status_valid, sb_if.i_status} = (k < stim.size()) ? stim[k] : 4'b0000;
         if (k == wr_cyc) begin
            sb_if.i_gld_we   = 1'b1;
            sb_if.i_gld_addr = '0;
            sb_if.i_gld_data = 3'b111;
         end
         step();
         sb_if.i_status_valid = 1'b0;
         sb_if.i_gld_we       = 1'b0;
         if (k == exit_k - 1) chk("done_not_early", 32'(sb_if.o_done), 32'd0);
      end

      chk("done", 32'(sb_if.o_done), 32'd1);
      chk("busy_end", 32'(sb_if.o_busy), 32'd0);
      chk("correct_cnt", 32'(sb_if.o_correct_cnt), 32'(n_ok));
      chk("error_cnt", 32'(sb_if.o_error_cnt), 32'(n_bad));
      chk("err_vld", 32'(sb_if.o_err_vld), 32'(first_seen));
      if (first_seen) begin
         chk("err_idx", 32'(sb_if.o_err_idx), 32'(first_idx));
         chk("err_got", 32'(sb_if.o_err_got), 32'(first_got));
      end
      chk("pass", 32'(sb_if.o_pass), 32'(pass));
      chk("timeout", 32'(sb_if.o_timeout), 32'(tmo));
      if (tmo) chk("cycle_cnt_tmo", 32'(sb_if.o_cycle_cnt), 32'(MAX_CYCLE - 1));

      // statuses in DONE are ignored and results hold
      sb_if.i_status_valid = 1'b1;
      sb_if.i_status       = 3'($urandom);
      step();
      sb_if.i_status_valid = 1'b0;
      chk("done_hold_err", 32'(sb_if.o_error_cnt), 32'(n_bad));
      chk("done_hold_pass", 32'(sb_if.o_pass), 32'(pass));
   endtask

   initial begin
      int len;
      sb_if.i_gld_we = 1'b0; sb_if.i_gld_addr = '0; sb_if.i_gld_data = '0;
      sb_if.i_pat_len = '0; sb_if.i_start = 1'b0;
      sb_if.i_status = '0; sb_if.i_status_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) gold[i] = 3'b000;

      // reset state
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
      chk("rst_busy", 32'(sb_if.o_busy), 32'd0);
      chk("rst_done", 32'(sb_if.o_done), 32'd0);
      chk("rst_pass", 32'(sb_if.o_pass), 32'd0);
      chk("rst_tmo", 32'(sb_if.o_timeout), 32'd0);
      chk("rst_corr", 32'(sb_if.o_correct_cnt), 32'd0);
      chk("rst_err", 32'(sb_if.o_error_cnt), 32'd0);
      chk("rst_errvld", 32'(sb_if.o_err_vld), 32'd0);
      chk("rst_cyc", 32'(sb_if.o_cycle_cnt), 32'd0);

      // clean pass
      load(0, 3'b001); load(1, 3'b010); load(2, 3'b000); load(3, 3'b101);
      stim = '{4'b1001, 4'b1010, 4'b1000, 4'b1101};
      run(4, -1);
      chk("t1_pass", 32'(sb_if.o_pass), 32'd1);

      // single mismatch at index 1
      stim = '{4'b1001, 4'b1011, 4'b1000, 4'b1101};
      run(4, -1);
      chk("t2_err_idx", 32'(sb_if.o_err_idx), 32'd1);
      chk("t2_err_got", 32'(sb_if.o_err_got), 32'd3);

      // surplus status past the pattern length
      load(0, 3'b001); load(1, 3'b101);
      stim = '{4'b1001, 4'b1000, 4'b1101};
      run(2, -1);
      chk("t3_err_cnt", 32'(sb_if.o_error_cnt), 32'd2);

      // timeout with no statuses
      stim = {};
      run(4, -1);
      chk("t4_tmo", 32'(sb_if.o_timeout), 32'd1);

      // end code on the timeout cycle wins
      stim = {};
      for (int i = 0; i < MAX_CYCLE - 1; i++) stim.push_back(4'b0000);
      stim.push_back(4'b1100);
      run(4, -1);
      chk("t5_no_tmo", 32'(sb_if.o_timeout), 32'd0);

      // mid-run reset, then rerun without reloading
      load(0, 3'b001); load(1, 3'b010); load(2, 3'b000); load(3, 3'b101);
      sb_if.i_pat_len = 7'd4; sb_if.i_start = 1'b1;
      step();
      sb_if.i_start = 1'b0;
      sb_if.i_status_valid = 1'b1; sb_if.i_status = 3'b001; step();
      sb_if.i_status = 3'b010; step();
      sb_if.i_status_valid = 1'b0;
      chk("mid_corr", 32'(sb_if.o_correct_cnt), 32'd2);
      rst_n = 1'b0; step(); rst_n = 1'b1;
      chk("mid_rst_busy", 32'(sb_if.o_busy), 32'd0);
      chk("mid_rst_corr", 32'(sb_if.o_correct_cnt), 32'd0);
      stim = '{4'b1001, 4'b1010, 4'b1000, 4'b1101};
      run(4, -1);
      chk("t6_pass", 32'(sb_if.o_pass), 32'd1);

      // golden write during RUN is dropped; re-run from DONE
      run(4, 0);
      chk("t7_pass", 32'(sb_if.o_pass), 32'd1);
      run(4, -1);

      // write and start on the same edge: run sees the new value
      sb_if.i_gld_we = 1'b1; sb_if.i_gld_addr = '0; sb_if.i_gld_data = 3'b011;
      gold[0] = 3'b011;
      stim = '{4'b1011, 4'b1010, 4'b1000, 4'b1101};
      run(4, -1);
      chk("t8_pass", 32'(sb_if.o_pass), 32'd1);

      // randomized runs
      for (int r = 0; r < 20; r++) begin
         len = $urandom_range(1, 6);
         for (int i = 0; i < len - 1; i++) load(i, rand_non_end());
         load(len - 1, ($urandom_range(0, 1) == 0) ? 3'b100 : 3'b101);
         stim = {};
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 1) == 1) stim.push_back(4'b0000);
            if (i == len - 1 && $urandom_range(0, 3) == 0)
               stim.push_back({1'b1, rand_non_end()});
            if ($urandom_range(0, 4) == 0) stim.push_back({1'b1, 3'($urandom)});
            else stim.push_back({1'b1, gold[i]});
         end
         run(len, ($urandom_range(0, 3) == 0) ? 0 : -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/status_scoreboard.md
Name: status_scoreboard

Overview:
- Synthesizable self-checking scoreboard for the RISC-V core's status stream (o_status / o_status_valid).
- Holds a loadable golden status sequence of parametrised depth and compares every valid status against the next golden entry.
- Counts passes and errors, records the first mismatch, and detects end-of-program and runtime timeout.
- Sits beside core/data_mem in FPGA or emulation builds.

Parameters:
STATUS_W, 3, width of status code
DEPTH, 64, golden entries (power of two)
ADDR_W, 6, log2(DEPTH)
MAX_CYCLE, 120000, RUN cycles before timeout
CYC_W, 17, cycle counter width, must satisfy 2^CYC_W > MAX_CYCLE
END_A, 3'b100, first terminating code
END_B, 3'b101, second terminating code

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_gld_we  in  1  golden write strobe, honoured only in IDLE/DONE
i_gld_addr  in  ADDR_W  golden write index
i_gld_data  in  STATUS_W  golden write value
i_pat_len  in  ADDR_W+1  expected status count (1..DEPTH), sampled on start
i_start  in  1  begin run
i_status  in  STATUS_W  core status
i_status_valid  in  1  core status valid
o_busy  out  1  high in RUN
o_done  out  1  high in DONE
o_pass  out  1  valid when o_done
o_timeout  out  1  run ended by timeout
o_correct_cnt  out  ADDR_W+1  matching statuses
o_error_cnt  out  ADDR_W+1  mismatching or surplus statuses
o_err_vld  out  1  a first mismatch has been captured
o_err_idx  out  ADDR_W+1  index of first mismatch
o_err_got  out  STATUS_W  status value at first mismatch
o_cycle_cnt  out  CYC_W  RUN cycles elapsed

Behaviour:
- Reset (i_rst_n=0 at posedge) clears:
  - state to IDLE
  - all outputs and counters to 0
  - internal index and latched length to 0
- Reset does not clear golden storage; contents survive reset, including reset mid-RUN.
- FSM states: IDLE, RUN, DONE.
  - IDLE: i_start -> RUN.
  - RUN: end code or timeout -> DONE.
  - DONE: i_start -> RUN (re-run without reload).
  - i_start in RUN is ignored.
- Entering RUN, all at the start edge:
  - latch i_pat_len
  - clear index, counters, err fields, o_cycle_cnt, o_pass, o_timeout
- Golden writes:
  - take effect at the posedge in IDLE/DONE.
  - dropped in RUN.
  - write and start in the same cycle: the write lands, and the run uses the new value.
- In RUN, each posedge with i_status_valid=1:
  - If idx < latched length and i_status == golden[idx]: correct_cnt+1.
  - Otherwise (mismatch, or surplus status with idx >= latched length): error_cnt+1.
  - On the first error only: capture o_err_idx=idx, o_err_got=i_status, and set o_err_vld.
  - idx+1, saturating at 2^(ADDR_W+1)-1.
  - All counters saturate and never wrap.
- Compare latency: counters reflect a status at the posedge it is sampled, visible the following cycle. Golden read is asynchronous from idx.
- Termination:
  - A valid status equal to END_A or END_B is compared and counted as above, then the state goes to DONE on the same edge; o_done is visible the next cycle.
  - o_cycle_cnt increments every RUN cycle. When it equals MAX_CYCLE-1 and no terminating status is sampled that edge, go to DONE with o_timeout=1.
  - Terminating status and timeout on the same edge: the status wins, o_timeout=0.
- o_pass, registered on entry to DONE:
  - = (error_cnt_next==0) && (correct_cnt_next==latched length) && !timeout
  - held stable in DONE.
- i_status_valid in IDLE/DONE is ignored; no counter changes.
- Status valid on the start edge is ignored; comparison starts the cycle after entering RUN.

Test Plan:
- Load golden {001,010,000,101}, len=4, start; drive the same four statuses on consecutive cycles -> correct=4, error=0, o_pass=1, o_done one cycle after the 101, o_err_vld=0.
- Same load; drive 001,011,000,101 -> error=1, correct=3, o_err_idx=1, o_err_got=011, o_pass=0.
- len=2, golden {001,101}; drive 001,000,101 -> 000 at idx1 and 101 at idx2 (surplus) both count as errors: error=2, correct=1, o_err_idx=1, o_pass=0.
- MAX_CYCLE=20, start, no valid status -> o_timeout=1, o_done=1, o_cycle_cnt=19, o_pass=0; second case: a 100 sampled exactly at cycle 19 -> o_timeout=0.
- Mid-RUN reset after 2 statuses, then restart with the same len and statuses without reloading golden -> counters restart from 0 and the run passes (golden retained).
- Golden write attempted during RUN at idx0 with 111 -> ignored; the original 001 still matches; in DONE, i_start re-runs with cleared counters.
